// File: rtl/ivl_uvm_ovl_clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
// The legality rule lives here so the divider and its checkers agree on it.
package ivl_uvm_ovl_clk_pkg;

  localparam int PERIOD_CNT_W = 32;
  localparam int CFG_CNT_W    = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } clk_state_t;

  typedef struct packed {
    logic [CFG_CNT_W-1:0] div;
    logic [CFG_CNT_W-1:0] high;
  } clk_cfg_t;

  // A period needs at least one high and one low cycle.
  function automatic logic cfg_legal(input logic [31:0] div, input logic [31:0] high);
    return (div >= 32'd2) && (high >= 32'd1) && (high < div);
  endfunction

endpackage

// File: rtl/ivl_uvm_ovl_clk_div_if.sv
// Configuration handshake for the clock divider: ratio/high-time offer,
// ready back-pressure and an illegal-config error pulse.
interface ivl_uvm_ovl_clk_div_if #(
  parameter int CNT_W = 16
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_high;
  logic             cfg_err;

  modport master (output cfg_valid, cfg_div, cfg_high, input cfg_ready, cfg_err);
  modport slave  (input cfg_valid, cfg_div, cfg_high, output cfg_ready, cfg_err);
endinterface

// File: rtl/ivl_uvm_ovl_clk_div.sv
// Programmable integer clock divider with duty control. New ratio/duty is
// only applied at a period boundary, so clk_div never glitches.
module ivl_uvm_ovl_clk_div
  import ivl_uvm_ovl_clk_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int DEF_DIV  = 2,
  parameter int DEF_HIGH = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  ivl_uvm_ovl_clk_div_if.slave    cfg,
  output logic                    clk_div,
  output logic                    rise_stb,
  output logic                    fall_stb,
  output logic                    active,
  output logic [PERIOD_CNT_W-1:0] period_cnt
);

  clk_state_t r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_div, w_div_nxt;
  logic [CNT_W-1:0] r_high, w_high_nxt;
  logic [CNT_W-1:0] r_pdiv, w_pdiv_nxt;
  logic [CNT_W-1:0] r_phigh, w_phigh_nxt;
  logic             r_pend, w_pend_nxt;
  logic             r_clk, w_clk_nxt;
  logic             r_rise, r_fall, r_err, w_err_nxt;
  logic [PERIOD_CNT_W-1:0] r_pcnt;

  logic w_xfer, w_legal, w_bnd, w_take;

  // Ready drops only while a config waits for the boundary.
  assign w_xfer  = cfg.cfg_valid && !r_pend;
  assign w_legal = cfg_legal(32'(cfg.cfg_div), 32'(cfg.cfg_high));
  assign w_take  = w_xfer && w_legal;
  assign w_bnd   = (r_cnt == r_div - CNT_W'(1));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_div_nxt   = r_div;
    w_high_nxt  = r_high;
    w_pdiv_nxt  = r_pdiv;
    w_phigh_nxt = r_phigh;
    w_pend_nxt  = r_pend;
    w_err_nxt   = w_xfer && !w_legal;
    case (r_state)
      IDLE: begin
        if (w_take) begin
          w_div_nxt  = cfg.cfg_div;
          w_high_nxt = cfg.cfg_high;
        end
        if (en) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        if (w_bnd) begin
          w_cnt_nxt = '0;
          if (r_pend) begin
            w_div_nxt  = r_pdiv;
            w_high_nxt = r_phigh;
            w_pend_nxt = 1'b0;
          end else if (w_take) begin
            w_div_nxt  = cfg.cfg_div;
            w_high_nxt = cfg.cfg_high;
          end
          w_state_nxt = en ? RUN : IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (w_take) begin
            w_pend_nxt  = 1'b1;
            w_pdiv_nxt  = cfg.cfg_div;
            w_phigh_nxt = cfg.cfg_high;
          end
          w_state_nxt = en ? RUN : STOPPING;
        end
      end
    endcase
    w_clk_nxt = (w_state_nxt != IDLE) && (w_cnt_nxt < w_high_nxt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_div   <= CNT_W'(DEF_DIV);
      r_high  <= CNT_W'(DEF_HIGH);
      r_pdiv  <= '0;
      r_phigh <= '0;
      r_pend  <= 1'b0;
      r_clk   <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_err   <= 1'b0;
      r_pcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_div   <= w_div_nxt;
      r_high  <= w_high_nxt;
      r_pdiv  <= w_pdiv_nxt;
      r_phigh <= w_phigh_nxt;
      r_pend  <= w_pend_nxt;
      r_clk   <= w_clk_nxt;
      r_rise  <= w_clk_nxt & ~r_clk;
      r_fall  <= ~w_clk_nxt & r_clk;
      r_err   <= w_err_nxt;
      r_pcnt  <= r_pcnt + PERIOD_CNT_W'(r_rise);
    end
  end

  assign clk_div       = r_clk;
  assign rise_stb      = r_rise;
  assign fall_stb      = r_fall;
  assign active        = (r_state != IDLE);
  assign period_cnt    = r_pcnt;
  assign cfg.cfg_ready = !r_pend;
  assign cfg.cfg_err   = r_err;

endmodule

// File: tb/tb_ivl_uvm_ovl_clk_div.sv
// Bench for the clock divider: cycle-level behavioural model compared every
// cycle, plus literal waveform pins for the directed scenarios.
module tb_ivl_uvm_ovl_clk_div;
  import ivl_uvm_ovl_clk_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        clk_div, rise_stb, fall_stb, active;
  logic [31:0] period_cnt;

  ivl_uvm_ovl_clk_div_if #(.CNT_W(16)) cif ();

  ivl_uvm_ovl_clk_div #(.CNT_W(16), .DEF_DIV(2), .DEF_HIGH(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .cfg        (cif),
    .clk_div    (clk_div),
    .rise_stb   (rise_stb),
    .fall_stb   (fall_stb),
    .active     (active),
    .period_cnt (period_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: position within the current period plus the live/pending ratio.
  typedef struct {
    bit          run;
    int unsigned pos, div, high;
    bit          pend;
    int unsigned pdiv, phigh;
    bit          clk, rise, fall, err, ready;
    int unsigned pcnt;
  } mdl_t;

  function automatic mdl_t mreset();
    mdl_t r;
    r.run = 0; r.pos = 0; r.div = 2; r.high = 1;
    r.pend = 0; r.pdiv = 0; r.phigh = 0;
    r.clk = 0; r.rise = 0; r.fall = 0; r.err = 0; r.ready = 1; r.pcnt = 0;
    return r;
  endfunction

  function automatic mdl_t mstep(mdl_t m, bit rn, bit e, bit v, int unsigned d, int unsigned h);
    mdl_t n = m;
    bit acc = v && m.ready;
    bit ok = acc && cfg_legal(d, h);
    if (!rn) return mreset();
    n.err  = acc && !cfg_legal(d, h);
    n.pcnt = m.pcnt + (m.rise ? 1 : 0);
    if (!m.run) begin
      if (ok) begin n.div = d; n.high = h; end
      if (e) begin n.run = 1; n.pos = 0; end
    end else if (m.pos + 1 == m.div) begin
      if (m.pend) begin n.div = m.pdiv; n.high = m.phigh; n.pend = 0; end
      else if (ok) begin n.div = d; n.high = h; end
      n.pos = 0;
      n.run = e;
    end else begin
      n.pos = m.pos + 1;
      if (ok) begin n.pend = 1; n.pdiv = d; n.phigh = h; end
    end
    n.ready = !n.pend;
    n.clk   = n.run && (n.pos < n.high);
    n.rise  = n.clk && !m.clk;
    n.fall  = !n.clk && m.clk;
    return n;
  endfunction

  mdl_t m = mreset();

  always @(posedge clk)
    m <= mstep(m, rst_n, en, cif.cfg_valid, 32'(cif.cfg_div), 32'(cif.cfg_high));

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_clk_div", 32'(clk_div), 32'(m.clk));
      chk("m_rise", 32'(rise_stb), 32'(m.rise));
      chk("m_fall", 32'(fall_stb), 32'(m.fall));
      chk("m_active", 32'(active), 32'(m.run));
      chk("m_ready", 32'(cif.cfg_ready), 32'(m.ready));
      chk("m_err", 32'(cif.cfg_err), 32'(m.err));
      chk("m_pcnt", period_cnt, m.pcnt);
    end
  end

  task automatic offer(input int unsigned d, input int unsigned h);
    cif.cfg_valid = 1'b1;
    cif.cfg_div   = 16'(d);
    cif.cfg_high  = 16'(h);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (!active) done = 1;
    end
    n_chk++;
    if (!done) begin
      n_fail++;
      $display("FAIL wait_idle actual=active required=idle within 100 cycles");
    end
  endtask

  clk_cfg_t rc;

  initial begin
    cif.cfg_valid = 1'b0;
    cif.cfg_div   = '0;
    cif.cfg_high  = '0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    chk("rst_clk_div", 32'(clk_div), 0);
    chk("rst_active", 32'(active), 0);
    chk("rst_ready", 32'(cif.cfg_ready), 1);
    chk("rst_pcnt", period_cnt, 0);
    rst_n = 1'b1;

    // Defaults 2/1
    @(negedge clk);
    en = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c <= 4) chk("dflt_wave", 32'(clk_div), (c % 2 == 1) ? 1 : 0);
      if (c == 1) chk("dflt_rise1", 32'(rise_stb), 1);
    end
    chk("dflt_pcnt5", period_cnt, 5);

    // 5/2 programmed in IDLE
    en = 1'b0;
    wait_idle();
    offer(5, 2);
    @(negedge clk);
    cif.cfg_valid = 1'b0;
    en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("d5_wave", 32'(clk_div), (c % 5 < 2) ? 1 : 0);
      chk("d5_rise", 32'(rise_stb), (c % 5 == 0) ? 1 : 0);
      chk("d5_fall", 32'(fall_stb), (c % 5 == 2) ? 1 : 0);
    end

    // Glitch-free change 4/2 -> 6/3 offered at cnt=1
    en = 1'b0;
    wait_idle();
    offer(4, 2);
    @(negedge clk);
    cif.cfg_valid = 1'b0;
    en = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk("chg_wave", 32'(clk_div), (c <= 4) ? ((c <= 2) ? 1 : 0) : ((c <= 7) ? 1 : 0));
      if (c == 2) offer(6, 3);
      if (c == 3) begin cif.cfg_valid = 1'b0; chk("chg_ready_lo", 32'(cif.cfg_ready), 0); end
      if (c == 5) chk("chg_ready_hi", 32'(cif.cfg_ready), 1);
    end

    // Illegal configs while running
    offer(1, 1);
    @(negedge clk);
    cif.cfg_valid = 1'b0;
    chk("ill1_err", 32'(cif.cfg_err), 1);
    chk("ill1_ready", 32'(cif.cfg_ready), 1);
    @(negedge clk);
    offer(4, 4);
    @(negedge clk);
    cif.cfg_valid = 1'b0;
    chk("ill2_err", 32'(cif.cfg_err), 1);
    chk("ill2_ready", 32'(cif.cfg_ready), 1);
    repeat (8) @(negedge clk);

    // Graceful stop with 8/4, then restart during STOPPING
    en = 1'b0;
    wait_idle();
    offer(8, 4);
    @(negedge clk);
    cif.cfg_valid = 1'b0;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    for (int c = 2; c <= 9; c++) begin
      @(negedge clk);
      if (c <= 4) chk("stop_hi", 32'(clk_div), 1);
      if (c == 8) chk("stop_act8", 32'(active), 1);
      if (c == 9) begin
        chk("stop_act9", 32'(active), 0);
        chk("stop_clk9", 32'(clk_div), 0);
      end
    end
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    for (int c = 2; c <= 9; c++) begin
      @(negedge clk);
      chk("rst_act", 32'(active), 1);
      if (c == 6) en = 1'b1;
      if (c == 9) chk("restart_rise", 32'(rise_stb), 1);
    end

    // Reset mid-operation with a pending config (now at cnt=0 of 8/4)
    offer(3, 1);
    @(negedge clk);
    cif.cfg_valid = 1'b0;
    chk("mid_pend", 32'(cif.cfg_ready), 0);
    @(negedge clk);
    chk("mid_hi", 32'(clk_div), 1);
    rst_n = 1'b0;
    en = 1'b0;
    @(negedge clk);
    chk("mid_clk", 32'(clk_div), 0);
    chk("mid_active", 32'(active), 0);
    chk("mid_ready", 32'(cif.cfg_ready), 1);
    chk("mid_pcnt", period_cnt, 0);
    rst_n = 1'b1;
    en = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("mid_dflt", 32'(clk_div), (c % 2 == 1) ? 1 : 0);
    end

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 24) == 0) en = ~en;
      rst_n = ($urandom_range(0, 799) != 0);
      rc.div  = 16'($urandom_range(0, 9));
      rc.high = 16'($urandom_range(0, 32'(rc.div)));
      cif.cfg_valid = ($urandom_range(0, 5) == 0);
      cif.cfg_div   = rc.div;
      cif.cfg_high  = rc.high;
    end
    cif.cfg_valid = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
